pid_gain_sequencer: RTL and testbench
=====================================

// Module: pid_gain_sequencer
// PURPOSE
//  Host-facing gain table and bus sequencer for the bank of PID focus channels.
//  - Stores kp/ki/kd per channel, written by the host over Avalon-MM.
//  - On a commit, replays every dirty channel's gains as back-to-back Avalon-MM
//    writes into that channel's PID wrapper (addr 0=kp, 1=ki, 2=kd).
//  - Gives atomic-looking gain updates across all axes and a single host port.
// PARAMETERS
//  NUM_CH  6  number of PID channels driven; legal range 1..7
//  GAIN_W 16  gain/data width; must equal PID wrapper writedata width
// PORTS
//  clk             in   1         system clock
//  reset_n         in   1         async active-low reset
//  s_address       in   5         host addr = {ch[2:0], g[1:0]}; g 0=kp 1=ki 2=kd 3=rsvd
//  s_writedata     in   16        host write data
//  s_write         in   1         host write strobe
//  s_chipselect    in   1         host select
//  s_readdata      out  16        host read data, combinational
//  m_chipselect    out  NUM_CH    one-hot select of target PID wrapper
//  m_address       out  3         wrapper register address (0..2)
//  m_writedata     out  16        wrapper write data
//  m_write         out  1         wrapper write strobe
//  m_readdata_flat in   NUM_CH*16 wrapper readdata, ch0 in [15:0]; used only with verify
//  busy            out  1         sequence in progress
// BEHAVIOUR
//  - Reset (async, immediate): table=0, dirty=0, FSM=IDLE, all m_* and busy=0, STATUS=0.
//  - Host map, when s_chipselect=1:
//    - ch<NUM_CH, g<3: R/W gain. A write sets dirty[ch].
//    - addr 28 CTRL (W): bit0=commit; bit1=clear sticky bits done/overrun/verr.
//    - addr 29 STATUS (R): [0] busy, [1] done, [2] overrun, [3] verr, [6:4] err_ch,
//      [15:8] dirty mask, zero-extended.
//    - All other addresses: read 0, writes ignored.
//  - FSM states: IDLE -> SCAN -> WR_KP -> WR_KI -> WR_KD -> SCAN ... -> DONE -> IDLE.
//  - Commit:
//    - Commit in IDLE enters SCAN on the next edge.
//    - Commit when not IDLE is ignored and sets overrun.
//  - SCAN: picks the lowest dirty ch >= cursor, then clears that dirty bit.
//    - Per-channel walk takes 0 cycles: combinational priority pick.
//    - If no channel remains, go to DONE.
//  - WR_*: one cycle each.
//    - m_chipselect=1<<ch, m_write=1, m_address=0/1/2.
//    - m_writedata = live table value in that cycle; the target accepts with zero wait.
//  - DONE: one cycle; sets done sticky; returns to IDLE.
//  - Latency: commit with k dirty channels -> first write 2 cycles after the commit edge.
//    - Writes are 3 cycles per channel, plus 1 SCAN cycle per channel.
//    - busy=1 from SCAN entry through DONE inclusive.
//  - Commit with zero dirty channels: SCAN -> DONE with no bus writes; done still set.
//  - Host write to a channel during a sequence:
//    - Same cycle as that channel's dirty clear: dirty stays set; the write wins.
//    - Any later write also re-sets dirty; the value goes out on the next commit.
//  - Simultaneous CTRL commit and clear: clear applied first, then commit rules.
//  - Reset mid-sequence: bus released immediately; remaining channels are not
//    written; the table is lost by design.
//  - m_* are 0 whenever not in WR_*/RD_* states.
// CONFIGURATION
//  - PID_SEQ_VERIFY_EN defined:
//    - Each WR_* is followed by RD_* (one cycle): m_chipselect and m_address held,
//      m_write=0.
//    - m_readdata_flat[ch] is compared against the table value.
//    - On mismatch, verr=1 and err_ch=ch (first error only); the sequence continues.
//    - Cost: 7 cycles per channel.
//  - Not defined: no RD_* states; verr and err_ch are tied 0; m_readdata_flat unused.
// TESTING
//  1. Release reset, read STATUS -> 0x0000; all m_* = 0; busy = 0.
//  2. Write ch0 kp/ki/kd = 0x0100/0x0010/0x0001, then commit:
//     - Bus sees cs=6'b000001 with addr 0,1,2 and data 0x0100,0x0010,0x0001 on 3
//       consecutive cycles.
//     - STATUS reads 0x0002 afterwards.
//  3. Dirty ch2 and ch5 only, then commit:
//     - Exactly 6 writes: ch2 first (cs=6'b000100), then ch5 (6'b100000).
//     - dirty mask reads 0 afterwards.
//  4. Commit while busy -> no extra writes; overrun=1. Clear via CTRL bit1 -> STATUS=0.
//  5. Commit with nothing dirty -> no m_write pulse; done=1 within 2 cycles.
//  6. Assert reset_n=0 during ch1 WR_KI -> m_write/cs drop in the same cycle, without
//     waiting for a clock edge; busy=0.
//  7. (VERIFY_EN) Model ch1 ki readback fixed at 0x0000, table 0x1234:
//     - verr=1 and err_ch=1.
//     - ch1 kd and later channels are still written.

Source files
------------

// File: rtl/pid_gain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pid_gain_sequencer
// Purpose  : Host gain table for the PID focus channels. A commit replays every
//            dirty channel's kp/ki/kd into its PID wrapper as Avalon-MM writes.
// Options  : PID_SEQ_VERIFY_EN adds a read-back check after every bus write.
// Revision : 1.0
// ============================================================================
module pid_gain_sequencer #(
  parameter int NUM_CH = 6,
  parameter int GAIN_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [4:0]               s_address,
  input  logic [GAIN_W-1:0]        s_writedata,
  input  logic                     s_write,
  input  logic                     s_chipselect,
  output logic [GAIN_W-1:0]        s_readdata,
  output logic [NUM_CH-1:0]        m_chipselect,
  output logic [2:0]               m_address,
  output logic [GAIN_W-1:0]        m_writedata,
  output logic                     m_write,
  input  logic [NUM_CH*GAIN_W-1:0] m_readdata_flat,
  output logic                     busy
);

  localparam logic [4:0] ADDR_CTRL   = 5'd28;
  localparam logic [4:0] ADDR_STATUS = 5'd29;
  localparam logic [3:0] NUM_CH_L    = 4'(NUM_CH);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SCAN  = 4'd1,
    ST_WR_KP = 4'd2,
    ST_WR_KI = 4'd3,
    ST_WR_KD = 4'd4,
    ST_DONE  = 4'd5
`ifdef PID_SEQ_VERIFY_EN
    ,
    ST_RD_KP = 4'd6,
    ST_RD_KI = 4'd7,
    ST_RD_KD = 4'd8
`endif
  } state_t;

  state_t              state_q;
  logic [2:0]          ch_q;
  logic [2:0]          cursor_q;
  logic [NUM_CH-1:0]   dirty_q, dirty_d;
  logic [GAIN_W-1:0]   gain_q [NUM_CH][3];
  logic [GAIN_W-1:0]   gain_d [NUM_CH][3];
  logic                done_q, overrun_q, verr_q;
  logic [2:0]          err_ch_q;
  logic [NUM_CH-1:0]   m_cs_q;
  logic [2:0]          m_addr_q;
  logic                m_write_q;

  logic [2:0]          host_ch;
  logic [1:0]          host_g;
  logic                gain_hit, gain_wr, ctrl_wr, commit, clear;
  logic                found;
  logic [2:0]          pick;
  logic [NUM_CH-1:0]   pick_oh;
  logic [15:0]         status;

  assign host_ch  = s_address[4:2];
  assign host_g   = s_address[1:0];
  assign gain_hit = s_chipselect && ({1'b0, host_ch} < NUM_CH_L) && (host_g != 2'd3);
  assign gain_wr  = gain_hit && s_write;
  assign ctrl_wr  = s_chipselect && s_write && (s_address == ADDR_CTRL);
  assign commit   = ctrl_wr && s_writedata[0];
  assign clear    = ctrl_wr && s_writedata[1];

  // Lowest dirty channel at or above the cursor; resolved within the SCAN cycle.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (dirty_q[i] && (3'(i) >= cursor_q)) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      pick_oh[i] = (pick == 3'(i));
    end
  end

  always_comb begin
    status             = '0;
    status[0]          = busy;
    status[1]          = done_q;
    status[2]          = overrun_q;
    status[3]          = verr_q;
    status[6:4]        = err_ch_q;
    status[8 +: NUM_CH] = dirty_q;
  end

  always_comb begin
    s_readdata = '0;
    if (gain_hit) begin
      s_readdata = gain_q[host_ch][host_g];
    end else if (s_chipselect && (s_address == ADDR_STATUS)) begin
      s_readdata = GAIN_W'(status);
    end
  end

  // A host write in the same cycle as the SCAN clear keeps the channel dirty.
  always_comb begin
    gain_d  = gain_q;
    dirty_d = dirty_q;
    if ((state_q == ST_SCAN) && found) begin
      dirty_d[pick] = 1'b0;
    end
    if (gain_wr) begin
      gain_d[host_ch][host_g] = s_writedata;
      dirty_d[host_ch]        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int g = 0; g < 3; g++) begin
          gain_q[c][g] <= '0;
        end
      end
      dirty_q <= '0;
    end else begin
      gain_q  <= gain_d;
      dirty_q <= dirty_d;
    end
  end

`ifdef PID_SEQ_VERIFY_EN
  logic [GAIN_W-1:0] rd_word;
  logic              rd_mismatch;

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 3'(c)) begin
        rd_word = m_readdata_flat[c*GAIN_W +: GAIN_W];
      end
    end
    rd_mismatch = (rd_word != gain_q[ch_q][m_addr_q[1:0]]);
  end
`else
  logic unused_rd;
  assign unused_rd = ^m_readdata_flat;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      cursor_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      verr_q    <= 1'b0;
      err_ch_q  <= '0;
      m_cs_q    <= '0;
      m_addr_q  <= '0;
      m_write_q <= 1'b0;
    end else begin
      if (clear) begin
        done_q    <= 1'b0;
        overrun_q <= 1'b0;
        verr_q    <= 1'b0;
        err_ch_q  <= '0;
      end
      if (commit && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
`ifdef PID_SEQ_VERIFY_EN
      if (((state_q == ST_RD_KP) || (state_q == ST_RD_KI) || (state_q == ST_RD_KD))
          && rd_mismatch && !verr_q) begin
        verr_q   <= 1'b1;
        err_ch_q <= ch_q;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (commit) begin
            state_q  <= ST_SCAN;
            cursor_q <= '0;
          end
        end
        ST_SCAN: begin
          if (found) begin
            ch_q      <= pick;
            cursor_q  <= pick + 3'd1;
            state_q   <= ST_WR_KP;
            m_cs_q    <= pick_oh;
            m_addr_q  <= 3'd0;
            m_write_q <= 1'b1;
          end else begin
            state_q <= ST_DONE;
          end
        end
`ifdef PID_SEQ_VERIFY_EN
        ST_WR_KP: begin
          state_q   <= ST_RD_KP;
          m_write_q <= 1'b0;
        end
        ST_RD_KP: begin
          state_q   <= ST_WR_KI;
          m_addr_q  <= 3'd1;
          m_write_q <= 1'b1;
        end
        ST_WR_KI: begin
          state_q   <= ST_RD_KI;
          m_write_q <= 1'b0;
        end
        ST_RD_KI: begin
          state_q   <= ST_WR_KD;
          m_addr_q  <= 3'd2;
          m_write_q <= 1'b1;
        end
        ST_WR_KD: begin
          state_q   <= ST_RD_KD;
          m_write_q <= 1'b0;
        end
        ST_RD_KD: begin
          state_q   <= ST_SCAN;
          m_cs_q    <= '0;
          m_addr_q  <= 3'd0;
          m_write_q <= 1'b0;
        end
`else
        ST_WR_KP: begin
          state_q  <= ST_WR_KI;
          m_addr_q <= 3'd1;
        end
        ST_WR_KI: begin
          state_q  <= ST_WR_KD;
          m_addr_q <= 3'd2;
        end
        ST_WR_KD: begin
          state_q   <= ST_SCAN;
          m_cs_q    <= '0;
          m_addr_q  <= 3'd0;
          m_write_q <= 1'b0;
        end
`endif
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          m_cs_q    <= '0;
          m_addr_q  <= 3'd0;
          m_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_chipselect = m_cs_q;
  assign m_address    = m_addr_q;
  assign m_write      = m_write_q;
  assign m_writedata  = m_write_q ? gain_q[ch_q][m_addr_q[1:0]] : '0;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pid_gain_sequencer.sv
`default_nettype none
// Bench for pid_gain_sequencer: table-driven host map vectors plus a bus-write
// scoreboard fed from the expected gain replay order.
module tb_pid_gain_sequencer;

  localparam int NUM_CH = 6;
  localparam int GAIN_W = 16;
`ifdef PID_SEQ_VERIFY_EN
  localparam int CYC_PER_CH = 7;
`else
  localparam int CYC_PER_CH = 4;
`endif

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [4:0]               s_address;
  logic [GAIN_W-1:0]        s_writedata;
  logic                     s_write;
  logic                     s_chipselect;
  logic [GAIN_W-1:0]        s_readdata;
  logic [NUM_CH-1:0]        m_chipselect;
  logic [2:0]               m_address;
  logic [GAIN_W-1:0]        m_writedata;
  logic                     m_write;
  logic [NUM_CH*GAIN_W-1:0] m_readdata_flat;
  logic                     busy;

  always #5 clk = ~clk;

  pid_gain_sequencer #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s_address       (s_address),
    .s_writedata     (s_writedata),
    .s_write         (s_write),
    .s_chipselect    (s_chipselect),
    .s_readdata      (s_readdata),
    .m_chipselect    (m_chipselect),
    .m_address       (m_address),
    .m_writedata     (m_writedata),
    .m_write         (m_write),
    .m_readdata_flat (m_readdata_flat),
    .busy            (busy)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [5:0]  cs;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  bus_t exp_q[$];

  // Wrapper register model; rd_fault pins ch1 ki readback to zero.
  logic [15:0] wrap_q [NUM_CH][3];
  logic        rd_fault = 1'b0;

  initial begin
    for (int c = 0; c < NUM_CH; c++)
      for (int g = 0; g < 3; g++)
        wrap_q[c][g] = '0;
  end

  always @(posedge clk) begin
    if (m_write)
      for (int c = 0; c < NUM_CH; c++)
        if (m_chipselect[c]) wrap_q[c][m_address[1:0]] <= m_writedata;
  end

  always_comb begin
    m_readdata_flat = '0;
    for (int c = 0; c < NUM_CH; c++)
      m_readdata_flat[c*GAIN_W +: GAIN_W] = wrap_q[c][m_address[1:0]];
    if (rd_fault && (m_address == 3'd1))
      m_readdata_flat[1*GAIN_W +: GAIN_W] = 16'h0000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && m_write) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL bus_unexpected: got cs=%b addr=%0d data=0x%h, required no write",
                 m_chipselect, m_address, m_writedata);
      end else begin
        bus_t e;
        e = exp_q.pop_front();
        check("bus_write", {13'd0, m_chipselect, m_address, m_writedata},
              {13'd0, e.cs, e.addr, e.data});
      end
    end
  end

  task automatic push(input int ch, input int g, input logic [15:0] d);
    bus_t e;
    e.cs   = 6'(1 << ch);
    e.addr = 3'(g);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic hwrite(input logic [4:0] a, input logic [15:0] d);
    s_chipselect = 1'b1;
    s_write      = 1'b1;
    s_address    = a;
    s_writedata  = d;
    @(posedge clk); #1;
    s_chipselect = 1'b0;
    s_write      = 1'b0;
  endtask

  task automatic hread(input logic [4:0] a, output logic [15:0] d);
    s_chipselect = 1'b1;
    s_write      = 1'b0;
    s_address    = a;
    @(negedge clk);
    d = s_readdata;
    @(posedge clk); #1;
    s_chipselect = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [15:0] exp);
    logic [15:0] d;
    hread(5'd29, d);
    check(name, 32'(d), 32'(exp));
  endtask

  // Counts busy cycles after a commit edge and the cycle index of the first write.
  task automatic wait_idle(input string name, output int cyc, output int first);
    bit ok = 1'b0;
    cyc   = 0;
    first = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      cyc++;
      if (m_write && first < 0) first = cyc;
    end
    if (!ok) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout: busy still 1 after 300 cycles, required 0", name);
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs [10];

  initial begin
    int          cyc, first;
    logic [15:0] d;
    bit          hit;

    vecs[0] = '{5'd8,  16'h0200, 16'h0200};
    vecs[1] = '{5'd9,  16'h0020, 16'h0020};
    vecs[2] = '{5'd10, 16'h0002, 16'h0002};
    vecs[3] = '{5'd11, 16'hBEEF, 16'h0000};
    vecs[4] = '{5'd20, 16'h5A5A, 16'h5A5A};
    vecs[5] = '{5'd21, 16'hA5A5, 16'hA5A5};
    vecs[6] = '{5'd22, 16'h00FF, 16'h00FF};
    vecs[7] = '{5'd24, 16'h1111, 16'h0000};
    vecs[8] = '{5'd30, 16'h2222, 16'h0000};
    vecs[9] = '{5'd31, 16'h3333, 16'h0000};

    reset_n      = 1'b0;
    s_address    = '0;
    s_writedata  = '0;
    s_write      = 1'b0;
    s_chipselect = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_m_cs", 32'(m_chipselect), 32'h0);
    check("rst_m_write", 32'(m_write), 32'h0);
    check("rst_m_addr", 32'(m_address), 32'h0);
    check("rst_m_data", 32'(m_writedata), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    check_status("rst_status", 16'h0000);

    // Single channel replay and latency
    hwrite(5'd0, 16'h0100);
    hwrite(5'd1, 16'h0010);
    hwrite(5'd2, 16'h0001);
    push(0, 0, 16'h0100);
    push(0, 1, 16'h0010);
    push(0, 2, 16'h0001);
    hwrite(5'd28, 16'h0001);
    wait_idle("ch0", cyc, first);
    check("ch0_first_write_cycle", 32'(first), 32'd2);
    check("ch0_busy_cycles", 32'(cyc), 32'(CYC_PER_CH + 2));
    check("ch0_queue_empty", 32'(exp_q.size()), 32'd0);
    check_status("ch0_status", 16'h0002);
    hwrite(5'd28, 16'h0002);
    check_status("clear_status", 16'h0000);

    // Table-driven host map: write, read back, then replay ch2 and ch5
    foreach (vecs[i]) begin
      hwrite(vecs[i].addr, vecs[i].wdata);
      hread(vecs[i].addr, d);
      check($sformatf("vec%0d_read", i), 32'(d), 32'(vecs[i].exp));
    end
    check_status("dirty_mask", 16'h2400);
    foreach (vecs[i])
      if (vecs[i].exp != 16'h0000)
        push(int'(vecs[i].addr[4:2]), int'(vecs[i].addr[1:0]), vecs[i].wdata);
    hwrite(5'd28, 16'h0001);
    wait_idle("ch25", cyc, first);
    check("ch25_busy_cycles", 32'(cyc), 32'(2 * CYC_PER_CH + 2));
    check("ch25_queue_empty", 32'(exp_q.size()), 32'd0);
    check_status("ch25_status", 16'h0002);

    // Commit while busy sets overrun and adds no writes
    hwrite(5'd4, 16'h0A0A);
    hwrite(5'd5, 16'h0B0B);
    hwrite(5'd6, 16'h0C0C);
    push(1, 0, 16'h0A0A);
    push(1, 1, 16'h0B0B);
    push(1, 2, 16'h0C0C);
    hwrite(5'd28, 16'h0001);
    hwrite(5'd28, 16'h0001);
    wait_idle("ovr", cyc, first);
    check("ovr_queue_empty", 32'(exp_q.size()), 32'd0);
    check_status("ovr_status", 16'h0006);
    hwrite(5'd28, 16'h0002);
    check_status("ovr_cleared", 16'h0000);

    // Commit with nothing dirty, combined with clear
    hwrite(5'd28, 16'h0003);
    wait_idle("empty", cyc, first);
    check("empty_busy_cycles", 32'(cyc), 32'd2);
    check("empty_no_write", 32'(first), 32'hFFFF_FFFF);
    check_status("empty_status", 16'h0002);

    // Asynchronous reset during ch1 WR_KI
    hwrite(5'd4, 16'h1357);
    hwrite(5'd5, 16'h2468);
    hwrite(5'd6, 16'h0F0F);
    push(1, 0, 16'h1357);
    hwrite(5'd28, 16'h0001);
    hit = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #2;
      if (m_write && (m_address == 3'd1)) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_ki", 32'(hit), 32'd1);
    check("rst_mid_cs_before", 32'(m_chipselect), 32'h02);
    reset_n = 1'b0;
    #1;
    check("rst_mid_write", 32'(m_write), 32'h0);
    check("rst_mid_cs", 32'(m_chipselect), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_status("rst_mid_status", 16'h0000);
    hread(5'd4, d);
    check("rst_mid_table_lost", 32'(d), 32'h0);
    check("rst_mid_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef PID_SEQ_VERIFY_EN
    // Read-back mismatch on ch1 ki flags verr/err_ch and the sequence continues
    rd_fault = 1'b1;
    hwrite(5'd4,  16'h0101);
    hwrite(5'd5,  16'h1234);
    hwrite(5'd6,  16'h0303);
    hwrite(5'd12, 16'h3003);
    hwrite(5'd13, 16'h3113);
    hwrite(5'd14, 16'h3223);
    push(1, 0, 16'h0101);
    push(1, 1, 16'h1234);
    push(1, 2, 16'h0303);
    push(3, 0, 16'h3003);
    push(3, 1, 16'h3113);
    push(3, 2, 16'h3223);
    hwrite(5'd28, 16'h0001);
    wait_idle("verr", cyc, first);
    check("verr_busy_cycles", 32'(cyc), 32'(2 * CYC_PER_CH + 2));
    check("verr_queue_empty", 32'(exp_q.size()), 32'd0);
    check_status("verr_status", 16'h001A);
    rd_fault = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
